// File: rtl/dm_access_ctrl.sv
// ============================================================================
// Module  : dm_access_ctrl
// Purpose : DM-stage data-memory access sequencer (req/ack) with pipeline stall.
//           Optional REQ timeout guarded by macro DM_TIMEOUT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dm_access_ctrl #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        DMMemRead,
  input  logic        DMMemWrite,
  input  logic [31:0] ALUresDM,
  input  logic [31:0] DMRead2,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        stall,
  output logic [31:0] DMReadData,
  output logic        mem_err
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam logic [1:0] ST_ERR  = 2'd3;

  logic [1:0] state;
  logic       access;
  logic       aligned;

  assign access  = DMMemRead | DMMemWrite;
  assign aligned = (ALUresDM[1:0] == 2'b00);

  // DONE deliberately releases the stall so the pipeline advances past the
  // instruction that was just serviced.
  assign stall = ((state == ST_IDLE) && access) || (state == ST_REQ) || (state == ST_ERR);

`ifdef DM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] tmo_cnt;
`else
  logic unused_cfg;
  assign unused_cfg = ^TIMEOUT_CYCLES;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'd0;
      mem_wdata  <= 32'd0;
      DMReadData <= 32'd0;
      mem_err    <= 1'b0;
`ifdef DM_TIMEOUT_EN
      tmo_cnt    <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (access) begin
            if (aligned) begin
              state     <= ST_REQ;
              mem_req   <= 1'b1;
              mem_we    <= DMMemWrite;
              mem_addr  <= ALUresDM;
              mem_wdata <= DMRead2;
            end else begin
              mem_err <= 1'b1;
              state   <= ST_DONE;
            end
          end
        end
        ST_REQ: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (!mem_we) begin
              DMReadData <= mem_rdata;
            end
            state <= ST_DONE;
`ifdef DM_TIMEOUT_EN
            tmo_cnt <= '0;
          end else if (tmo_cnt == CNT_LAST) begin
            tmo_cnt <= '0;
            state   <= ST_ERR;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
`endif
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        ST_ERR: begin
`ifdef DM_TIMEOUT_EN
          mem_req <= 1'b0;
          mem_err <= 1'b1;
          if (!mem_we) begin
            DMReadData <= 32'hDEADBEEF;
          end
`endif
          state <= ST_DONE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dm_access_ctrl.sv
// ============================================================================
// Module  : tb_dm_access_ctrl
// Purpose : Directed self-checking bench for dm_access_ctrl.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dm_access_ctrl;

  logic        clk;
  logic        rst_n;
  logic        DMMemRead;
  logic        DMMemWrite;
  logic [31:0] ALUresDM;
  logic [31:0] DMRead2;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        stall;
  logic [31:0] DMReadData;
  logic        mem_err;

  int tests;
  int fails;

  dm_access_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .DMMemRead (DMMemRead),
    .DMMemWrite(DMMemWrite),
    .ALUresDM  (ALUresDM),
    .DMRead2   (DMRead2),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .stall     (stall),
    .DMReadData(DMReadData),
    .mem_err   (mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; DMMemRead = 1'b0; DMMemWrite = 1'b0; ALUresDM = 32'd0;
    DMRead2 = 32'd0; mem_ack = 1'b0; mem_rdata = 32'd0;
    tick(); tick();
    tests++; if ({mem_req, mem_we, stall, mem_err} !== 4'b0000) begin
      fails++; $display("FAIL reset_flags: got %b, want 0000", {mem_req, mem_we, stall, mem_err}); end
    tests++; if ({mem_addr, mem_wdata, DMReadData} !== 96'd0) begin
      fails++; $display("FAIL reset_data: got %h %h %h, want all 0", mem_addr, mem_wdata, DMReadData); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_load();
    DMMemRead = 1'b1; ALUresDM = 32'h100; #1;
    tests++; if (stall !== 1'b1) begin fails++; $display("FAIL load_stall_idle: got %b, want 1", stall); end
    tick();
    tests++; if ({mem_req, mem_we, stall} !== 3'b101 || mem_addr !== 32'h100) begin
      fails++; $display("FAIL load_req: got req/we/stall %b addr %h, want 101 addr 00000100", {mem_req, mem_we, stall}, mem_addr); end
    mem_ack = 1'b1; mem_rdata = 32'h12345678;
    tick();
    mem_ack = 1'b0; DMMemRead = 1'b0; mem_rdata = 32'h0; #1;
    tests++; if ({mem_req, stall} !== 2'b00 || DMReadData !== 32'h12345678) begin
      fails++; $display("FAIL load_done: got req/stall %b data %h, want 00 data 12345678", {mem_req, stall}, DMReadData); end
    tick();
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL load_idle_stall: got %b, want 0", stall); end
  endtask

  task automatic test_store();
    DMMemWrite = 1'b1; ALUresDM = 32'h204; DMRead2 = 32'hA5A5A5A5;
    tick();
    DMMemWrite = 1'b0; DMRead2 = 32'h0; ALUresDM = 32'h0;
    for (int i = 0; i < 5; i++) begin
      #1;
      tests++;
      if ({mem_req, mem_we, stall} !== 3'b111 || mem_addr !== 32'h204 || mem_wdata !== 32'hA5A5A5A5) begin
        fails++;
        $display("FAIL store_hold[%0d]: got req/we/stall %b addr %h wdata %h, want 111 00000204 a5a5a5a5",
                 i, {mem_req, mem_we, stall}, mem_addr, mem_wdata);
      end
      if (i == 4) begin mem_ack = 1'b1; mem_rdata = 32'h0BADF00D; end
      tick();
    end
    mem_ack = 1'b0; #1;
    tests++; if ({mem_req, stall} !== 2'b00 || DMReadData !== 32'h12345678) begin
      fails++; $display("FAIL store_done: got req/stall %b data %h, want 00 data 12345678", {mem_req, stall}, DMReadData); end
    tick();
  endtask

  task automatic test_stray_ack_idle();
    mem_ack = 1'b1; mem_rdata = 32'hFFFF0000;
    tick(); tick();
    mem_ack = 1'b0; #1;
    tests++; if (mem_req !== 1'b0 || DMReadData !== 32'h12345678) begin
      fails++; $display("FAIL idle_ack_ignored: got req %b data %h, want 0 12345678", mem_req, DMReadData); end
  endtask

  task automatic test_read_write_both();
    DMMemRead = 1'b1; DMMemWrite = 1'b1; ALUresDM = 32'h300; DMRead2 = 32'h11223344;
    tick();
    DMMemRead = 1'b0; DMMemWrite = 1'b0; #1;
    tests++; if ({mem_req, mem_we} !== 2'b11 || mem_wdata !== 32'h11223344) begin
      fails++; $display("FAIL both_write: got req/we %b wdata %h, want 11 11223344", {mem_req, mem_we}, mem_wdata); end
    mem_ack = 1'b1; mem_rdata = 32'h55555555;
    tick();
    mem_ack = 1'b0; #1;
    tests++; if (DMReadData !== 32'h12345678) begin
      fails++; $display("FAIL both_no_load: got %h, want 12345678", DMReadData); end
    tick();
  endtask

  task automatic test_misaligned();
    DMMemRead = 1'b1; ALUresDM = 32'h103; #1;
    tests++; if (stall !== 1'b1) begin fails++; $display("FAIL misal_stall: got %b, want 1", stall); end
    tick();
    DMMemRead = 1'b0; #1;
    tests++; if ({mem_req, mem_err, stall} !== 3'b010) begin
      fails++; $display("FAIL misal_done: got req/err/stall %b, want 010", {mem_req, mem_err, stall}); end
    tick();
    DMMemRead = 1'b1; ALUresDM = 32'h400;
    tick();
    DMMemRead = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
    tick();
    mem_ack = 1'b0; #1;
    tests++; if (mem_err !== 1'b1 || DMReadData !== 32'hCAFEF00D) begin
      fails++; $display("FAIL misal_sticky: got err %b data %h, want 1 cafef00d", mem_err, DMReadData); end
    tick();
  endtask

  task automatic test_no_ack();
    DMMemRead = 1'b1; ALUresDM = 32'h500;
    tick();
    DMMemRead = 1'b0;
`ifdef DM_TIMEOUT_EN
    tick(); tick(); tick();
    tests++; if ({mem_req, stall} !== 2'b11) begin
      fails++; $display("FAIL tmo_req4: got req/stall %b, want 11", {mem_req, stall}); end
    tick();
    tests++; if (stall !== 1'b1) begin fails++; $display("FAIL tmo_err_stall: got %b, want 1", stall); end
    tick();
    tests++; if ({mem_req, mem_err, stall} !== 3'b010 || DMReadData !== 32'hDEADBEEF) begin
      fails++; $display("FAIL tmo_done: got req/err/stall %b data %h, want 010 deadbeef", {mem_req, mem_err, stall}, DMReadData); end
    tick();
    DMMemRead = 1'b1; ALUresDM = 32'h500;
    tick();
    DMMemRead = 1'b0;
`else
    for (int i = 0; i < 100; i++) tick();
    tests++; if ({mem_req, stall} !== 2'b11 || mem_addr !== 32'h500) begin
      fails++; $display("FAIL wait_forever: got req/stall %b addr %h, want 11 00000500", {mem_req, stall}, mem_addr); end
`endif
  endtask

  task automatic test_reset_in_req();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; #1;
    tests++; if ({mem_req, mem_we, stall, mem_err} !== 4'b0000 || {mem_addr, mem_wdata, DMReadData} !== 96'd0) begin
      fails++; $display("FAIL rst_req: got flags %b addr %h data %h, want 0000 0 0", {mem_req, mem_we, stall, mem_err}, mem_addr, DMReadData); end
    mem_ack = 1'b1; mem_rdata = 32'h87654321;
    tick();
    mem_ack = 1'b0; #1;
    tests++; if ({mem_req, stall} !== 2'b00 || DMReadData !== 32'd0) begin
      fails++; $display("FAIL rst_stray_ack: got req/stall %b data %h, want 00 0", {mem_req, stall}, DMReadData); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_load();
    test_store();
    test_stray_ack_idle();
    test_read_write_both();
    test_misaligned();
    test_no_ack();
    test_reset_in_req();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dm_access_ctrl.md
DM_ACCESS_CTRL -- requirements
Module: dm_access_ctrl

Purpose: sequences the DM-stage data-memory access to a multi-cycle memory over a req/ack handshake, and stalls the pipeline registers upstream of DM until the access completes.

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 16, max cycles waiting for mem_ack (used only with DM_TIMEOUT_EN).
REQ-002 clk  input  1  single clock, all logic on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 DMMemRead  input  1  DM-stage load request.
REQ-005 DMMemWrite  input  1  DM-stage store request.
REQ-006 ALUresDM  input  32  byte address of the access.
REQ-007 DMRead2  input  32  store data.
REQ-008 mem_ack  input  1  memory completes the current request, one-cycle pulse.
REQ-009 mem_rdata  input  32  load data, valid when mem_ack=1.
REQ-010 mem_req  output  1  request to memory, registered.
REQ-011 mem_we  output  1  1 = write, 0 = read, registered.
REQ-012 mem_addr  output  32  word-aligned address, registered.
REQ-013 mem_wdata  output  32  store data, registered.
REQ-014 stall  output  1  freezes the PC, IF/ID, ID/EX and EX/DM registers, combinational.
REQ-015 DMReadData  output  32  last completed load data, registered.
REQ-016 mem_err  output  1  sticky error flag.

Function
REQ-017 The FSM SHALL have four states: IDLE, REQ, DONE and ERR.
REQ-018 IDLE, access = DMMemRead|DMMemWrite, address aligned (ALUresDM[1:0]=0):
- next state REQ;
- on that edge, mem_req=1, mem_addr=ALUresDM, mem_wdata=DMRead2, mem_we=DMMemWrite.
REQ-019 When DMMemRead and DMMemWrite are both 1, the access SHALL be a write.
REQ-020 IDLE, access with ALUresDM[1:0]!=0:
- no mem_req;
- mem_err set;
- next state DONE.
REQ-021 stall SHALL be 1 in IDLE when an access is pending, and 1 throughout REQ and ERR; it SHALL be 0 in DONE and in IDLE with no access.
REQ-022 In REQ, mem_req, mem_we, mem_addr and mem_wdata SHALL hold stable until mem_ack=1.
REQ-023 In REQ with mem_ack=1:
- mem_req cleared on that edge;
- if mem_we=0, DMReadData=mem_rdata;
- next state DONE.
REQ-024 DONE SHALL last exactly one cycle with stall=0, then return to IDLE unconditionally, so the same instruction is never re-issued.
REQ-025 Minimum access latency SHALL be 3 cycles from access seen in IDLE to stall release, for mem_ack in the first REQ cycle.
REQ-026 mem_ack in IDLE, DONE or ERR SHALL be ignored.
REQ-027 A store SHALL NOT modify DMReadData.
REQ-028 mem_err, once set, SHALL stay 1 until reset.

Reset
REQ-029 With rst_n=0 at a clock edge:
- state=IDLE, timeout counter=0;
- mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, DMReadData=0, mem_err=0.
REQ-030 Reset during REQ SHALL drop mem_req on that edge; an mem_ack arriving afterwards SHALL be ignored.

Configuration
REQ-031 Macro DM_TIMEOUT_EN defined:
- a counter SHALL count REQ cycles;
- on the TIMEOUT_CYCLES-th REQ cycle without mem_ack, go to ERR (counter clears on leaving REQ);
- ERR SHALL clear mem_req, set mem_err, set DMReadData=32'hDEADBEEF for loads, and go to DONE next cycle.
REQ-032 Macro DM_TIMEOUT_EN undefined:
- no counter and no ERR transition;
- REQ SHALL wait indefinitely;
- mem_err SHALL be set only by misalignment.

Verification
REQ-033 Load, ALUresDM=0x100, mem_ack on 1st REQ cycle with mem_rdata=0x12345678 -> mem_req 1 cycle, DMReadData=0x12345678, stall high 2 cycles then low 1.
REQ-034 Store, ALUresDM=0x204, DMRead2=0xA5A5A5A5, mem_ack after 5 cycles -> mem_we=1, addr/data stable all 5 cycles, DMReadData unchanged, stall released in DONE.
REQ-035 DMMemRead=DMMemWrite=1 -> write issued, mem_we=1.
REQ-036 Load at ALUresDM=0x103 -> no mem_req, mem_err=1 and sticky, stall 1 cycle.
REQ-037 DM_TIMEOUT_EN, TIMEOUT_CYCLES=4, no mem_ack -> ERR after 4 REQ cycles, mem_err=1, DMReadData=0xDEADBEEF; without the macro, still in REQ after 100 cycles.
REQ-038 rst_n=0 during REQ, then stray mem_ack -> IDLE, all outputs 0, stray mem_ack ignored.
